conv_pe_sequencer: RTL and testbench
====================================

# conv_pe_sequencer

Control sequencer for the `Sub_top_CONV` PE array. After IFM and weight BRAM loading, it replaces the hand-timed `cal_start`/`PE_reset`/`PE_finish` stimulus with a cycle-exact FSM. It emits one reset/accumulate/finish window per OFM pixel over a full layer, and stalls between pixels when the OFM writer is not ready.

## Interface
- `NUM_PE`, 16, PE lanes driven.
- `CYCLES_PER_PIXEL`, 36, pixel window length (num_tiles × kernel_W); legal range ≥ 3.
- `NUM_PIXELS`, 3136, OFM pixels per layer (56×56); ≥ 1.
- `START_DELAY`, 2, cycles of `cal_start` before the first `PE_reset`; ≥ 1.
- `PIX_W`, 16, width of the pixel counter.

- `clk` in 1: clock.
- `reset` in 1: async, active-high.
- `start` in 1: layer start request, sampled in IDLE only.
- `abort` in 1: synchronous abort.
- `pe_mask` in NUM_PE: lanes to drive, captured on an accepted `start`.
- `ofm_ready` in 1: OFM writer can take the next pixel.
- `cal_start` out 1: calculation enable to the array.
- `PE_reset` out NUM_PE: per-PE accumulator clear pulse.
- `PE_finish` out NUM_PE: per-PE result-latch pulse.
- `pixel_idx` out PIX_W: index of the pixel currently in progress.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle end-of-layer pulse.

## Operation
- Reset values: all outputs 0; state IDLE; captured mask 0.
- All outputs are registered.
- States and behaviour:
  - IDLE: `start`=1 and `abort`=0 → capture `pe_mask`, load the delay counter, go to PRE.
  - PRE: `cal_start`=1 for START_DELAY cycles, then RST.
  - RST: `PE_reset`=mask for 1 cycle → ACC.
  - ACC: CYCLES_PER_PIXEL−2 cycles, no pulses → FIN.
  - FIN: `PE_finish`=mask for 1 cycle. `ofm_ready` is sampled this cycle:
    - ready=1, not the last pixel → `pixel_idx`+1, go to RST.
    - ready=1, last pixel → DONE.
    - ready=0 → WAIT.
  - WAIT: no pulses, `cal_start` held. Leave when `ofm_ready`=1:
    - not the last pixel → increment `pixel_idx`, go to RST.
    - last pixel → DONE.
  - DONE: `done`=1 for 1 cycle, `cal_start`=0 → IDLE.
- `cal_start` is high in PRE, RST, ACC, FIN and WAIT.
- `pixel_idx` clears to 0 on an accepted `start`. It holds through WAIT and after DONE.
- `start` outside IDLE is ignored. No queueing.
- `abort`=1 in any non-IDLE state → IDLE on the next edge. All pulses and `cal_start` drop, no `done` is issued, and `pixel_idx` holds.
- Simultaneous `abort` and `start` in IDLE: abort wins and `start` is dropped.
- `PE_reset` and `PE_finish` are never high in the same cycle.
- Bits with `pe_mask`=0 stay 0 throughout.
- The pixel counter compares against NUM_PIXELS−1. PIX_W must cover NUM_PIXELS; this is checked by an elaboration assertion.

## Timing
- `start` accepted at edge E. Counting edges from E:
  - `cal_start` rises after E.
  - First `PE_reset` is high in cycle E+START_DELAY+1.
  - First `PE_finish` is high in cycle E+START_DELAY+CYCLES_PER_PIXEL.
- With no stalls, the period between consecutive `PE_reset` pulses is exactly CYCLES_PER_PIXEL.
- Each WAIT cycle adds one cycle to that period.
- `done` is high in the cycle after the last FIN (or after the last WAIT exit).
- Unstalled layer latency, from `start` to `done`: START_DELAY + NUM_PIXELS×CYCLES_PER_PIXEL + 1 cycles.
- `reset` mid-layer forces reset values immediately (asynchronous).

## Configuration
- `CONV_SEQ_PERF_CNT_EN` defined: adds output `stall_cycles` (32 bits).
  - Clears on an accepted `start`.
  - Increments every WAIT cycle; saturates at 0xFFFFFFFF.
  - Holds after DONE or `abort`.
  - Reset value 0.
- `CONV_SEQ_PERF_CNT_EN` undefined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- Single layer, NUM_PIXELS=3, CYCLES_PER_PIXEL=36, START_DELAY=2, mask 0xFFFF, `ofm_ready`=1 → `PE_reset` at cycles 3, 39, 75 after `start` and `PE_finish` at 38, 74, 110; `done` at 111; `busy` falls after 111.
- Backpressure: `ofm_ready`=0 for 5 cycles after the second FIN → third `PE_reset` delayed by exactly 5 cycles; `pixel_idx` holds at 1 during WAIT; with the macro, `stall_cycles`=5.
- Mask 0x00F0 → only bits 4–7 of `PE_reset`/`PE_finish` ever pulse; `pe_mask` changes mid-layer have no effect.
- `abort` asserted in ACC of pixel 1 → IDLE next cycle, `cal_start`=0, no `done`, `pixel_idx`=1; a new `start` restarts from pixel 0.
- `start` while busy, and `start`+`abort` together in IDLE → both ignored; outputs unchanged.
- Async `reset` pulse mid-FIN → all outputs 0 without waiting for a clock edge; the next `start` runs a clean layer.

Source files
------------

// File: rtl/conv_pe_sequencer_if.sv
// rtl/conv_pe_sequencer_if.sv - Handshake/control bundle between a layer controller and conv_pe_sequencer
//
// Optional feature macro: CONV_SEQ_PERF_CNT_EN adds stall_cycles (32 bits, sequencer -> controller).
//
// Signals:
//   start, abort        controller -> sequencer  layer start request / synchronous abort
//   pe_mask[NUM_PE]     controller -> sequencer  lanes to drive, captured on an accepted start
//   ofm_ready           controller -> sequencer  OFM writer can take the next pixel
//   cal_start           sequencer -> controller  calculation enable to the PE array
//   PE_reset[NUM_PE]    sequencer -> controller  per-PE accumulator clear pulse
//   PE_finish[NUM_PE]   sequencer -> controller  per-PE result-latch pulse
//   pixel_idx[PIX_W]    sequencer -> controller  index of the pixel in progress
//   busy, done          sequencer -> controller  not-idle flag / end-of-layer pulse
// Modports: master = controller side, slave = sequencer side.
interface conv_pe_sequencer_if #(
   parameter int NUM_PE = 16,
   parameter int PIX_W  = 16
);
   logic              start;
   logic              abort;
   logic [NUM_PE-1:0] pe_mask;
   logic              ofm_ready;
   logic              cal_start;
   logic [NUM_PE-1:0] PE_reset;
   logic [NUM_PE-1:0] PE_finish;
   logic [PIX_W-1:0]  pixel_idx;
   logic              busy;
   logic              done;
`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0]       stall_cycles;

   modport master (
      output start, abort, pe_mask, ofm_ready,
      input  cal_start, PE_reset, PE_finish, pixel_idx, busy, done, stall_cycles
   );
   modport slave (
      input  start, abort, pe_mask, ofm_ready,
      output cal_start, PE_reset, PE_finish, pixel_idx, busy, done, stall_cycles
   );
`else
   modport master (
      output start, abort, pe_mask, ofm_ready,
      input  cal_start, PE_reset, PE_finish, pixel_idx, busy, done
   );
   modport slave (
      input  start, abort, pe_mask, ofm_ready,
      output cal_start, PE_reset, PE_finish, pixel_idx, busy, done
   );
`endif
endinterface

// File: rtl/conv_pe_sequencer.sv
// rtl/conv_pe_sequencer.sv - PE-array control sequencer: one reset/accumulate/finish window per OFM pixel
//
// Optional feature macro: CONV_SEQ_PERF_CNT_EN adds bus.stall_cycles, a saturating 32-bit count
// of cycles spent waiting for the OFM writer (cleared on an accepted start).
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    conv_pe_sequencer_if.slave
//            in : start, abort, pe_mask, ofm_ready
//            out: cal_start, PE_reset, PE_finish, pixel_idx, busy, done (, stall_cycles)
// All outputs are registered: the output process decodes the *next* state and the
// result is captured on the same edge as the state register.
module conv_pe_sequencer #(
   parameter int NUM_PE           = 16,
   parameter int CYCLES_PER_PIXEL = 36,
   parameter int NUM_PIXELS       = 3136,
   parameter int START_DELAY      = 2,
   parameter int PIX_W            = 16
) (
   input  logic               clk,
   input  logic               reset,
   conv_pe_sequencer_if.slave bus
);

   localparam int CNT_MAX = (START_DELAY > CYCLES_PER_PIXEL) ? START_DELAY : CYCLES_PER_PIXEL;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(START_DELAY - 1);
   localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(CYCLES_PER_PIXEL - 3);
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

   generate
      if (((NUM_PIXELS - 1) >> PIX_W) != 0) begin : g_pix_w_chk
         $error("conv_pe_sequencer: PIX_W too narrow for NUM_PIXELS");
      end
      if (NUM_PIXELS < 1) begin : g_npix_chk
         $error("conv_pe_sequencer: NUM_PIXELS must be >= 1");
      end
      if (CYCLES_PER_PIXEL < 3) begin : g_cpp_chk
         $error("conv_pe_sequencer: CYCLES_PER_PIXEL must be >= 3");
      end
      if (START_DELAY < 1) begin : g_sd_chk
         $error("conv_pe_sequencer: START_DELAY must be >= 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_RST, S_ACC, S_FIN, S_WAIT, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [NUM_PE-1:0] mask;
   logic              accept;
   logic              pix_inc;

   logic              cal_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic [NUM_PE-1:0] rst_nxt;
   logic [NUM_PE-1:0] fin_nxt;

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         mask          <= '0;
         bus.pixel_idx <= '0;
         bus.cal_start <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.PE_reset  <= '0;
         bus.PE_finish <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bus.cal_start <= cal_nxt;
         bus.busy      <= busy_nxt;
         bus.done      <= done_nxt;
         bus.PE_reset  <= rst_nxt;
         bus.PE_finish <= fin_nxt;
         if (accept) begin
            mask          <= bus.pe_mask;
            bus.pixel_idx <= '0;
         end else if (pix_inc) begin
            bus.pixel_idx <= bus.pixel_idx + PIX_W'(1);
         end
      end
   end

   // Next-state logic; abort outranks every other transition, including the pixel increment
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      pix_inc   = 1'b0;
      if (bus.abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  accept    = 1'b1;
                  state_nxt = S_PRE;
                  cnt_nxt   = PRE_LOAD;
               end
            end
            S_PRE: begin
               if (cnt == '0) state_nxt = S_RST;
               else           cnt_nxt   = cnt - CNT_W'(1);
            end
            S_RST: begin
               state_nxt = S_ACC;
               cnt_nxt   = ACC_LOAD;
            end
            S_ACC: begin
               if (cnt == '0) state_nxt = S_FIN;
               else           cnt_nxt   = cnt - CNT_W'(1);
            end
            S_FIN, S_WAIT: begin
               if (!bus.ofm_ready) begin
                  state_nxt = S_WAIT;
               end else if (bus.pixel_idx == LAST_PIX) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_RST;
                  pix_inc   = 1'b1;
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Output decode of the next state; the mask is already captured by the time RST is reached
   always_comb begin
      cal_nxt  = 1'b0;
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_DONE);
      rst_nxt  = '0;
      fin_nxt  = '0;
      case (state_nxt)
         S_PRE, S_ACC, S_WAIT: cal_nxt = 1'b1;
         S_RST: begin
            cal_nxt = 1'b1;
            rst_nxt = mask;
         end
         S_FIN: begin
            cal_nxt = 1'b1;
            fin_nxt = mask;
         end
         default: cal_nxt = 1'b0;
      endcase
   end

`ifdef CONV_SEQ_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.stall_cycles <= '0;
      end else if (accept) begin
         bus.stall_cycles <= '0;
      end else if ((state == S_WAIT) && (bus.stall_cycles != 32'hFFFF_FFFF)) begin
         bus.stall_cycles <= bus.stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb/tb_conv_pe_sequencer.sv - Self-checking bench for conv_pe_sequencer against a schedule model
module tb_conv_pe_sequencer;
   localparam int NPE   = 16;
   localparam int CPP   = 36;
   localparam int NPIX  = 3;
   localparam int SD    = 2;
   localparam int PW    = 16;
   localparam int OBS_W = 3 + 2 * NPE + PW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_pe_sequencer_if #(.NUM_PE(NPE), .PIX_W(PW)) bus ();

   conv_pe_sequencer #(
      .NUM_PE(NPE), .CYCLES_PER_PIXEL(CPP), .NUM_PIXELS(NPIX),
      .START_DELAY(SD), .PIX_W(PW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   int checks = 0;
   int passed = 0;

   int             stall [NPIX];
   int             abort_at;
   logic [NPE-1:0] cap_mask;
   int             last_pix;

   function automatic logic [OBS_W-1:0] observe();
      return {bus.cal_start, bus.busy, bus.done, bus.PE_reset, bus.PE_finish, bus.pixel_idx};
   endfunction

   function automatic int done_cycle();
      int t;
      t = SD + 1;
      for (int p = 0; p < NPIX; p++) t += CPP + stall[p];
      return t;
   endfunction

   // Expected outputs in cycle k after the accepting edge, from the pixel schedule:
   // reset of pixel p at SD+1+sum(CPP+stall), finish CPP-1 later, done after the last stall
   function automatic logic [OBS_W-1:0] model(input int k);
      int             kk, rst_k, fin_k, pix;
      logic           aborted, cal, bsy, dn;
      logic [NPE-1:0] r, f;
      aborted = (abort_at > 0) && (k > abort_at);
      kk      = aborted ? abort_at : k;
      r = '0; f = '0; pix = 0;
      rst_k = SD + 1;
      for (int p = 0; p < NPIX; p++) begin
         fin_k = rst_k + CPP - 1;
         if (kk >= rst_k) pix = p;
         if (kk == rst_k) r = cap_mask;
         if (kk == fin_k) f = cap_mask;
         rst_k = fin_k + 1 + stall[p];
      end
      cal = (kk >= 1) && (kk < rst_k);
      bsy = (kk >= 1) && (kk <= rst_k);
      dn  = (kk == rst_k);
      if (aborted) begin
         cal = 1'b0; bsy = 1'b0; dn = 1'b0; r = '0; f = '0;
      end
      return {cal, bsy, dn, r, f, PW'(pix)};
   endfunction

`ifdef CONV_SEQ_PERF_CNT_EN
   function automatic int model_stall(input int k);
      int lim, fin_k, n;
      lim   = ((abort_at > 0) && (k > abort_at)) ? abort_at + 1 : k;
      fin_k = SD + CPP;
      n     = 0;
      for (int p = 0; p < NPIX; p++) begin
         for (int j = fin_k + 1; j <= fin_k + stall[p]; j++) if (j < lim) n++;
         fin_k += CPP + stall[p];
      end
      return n;
   endfunction
`endif

   // 0: must be low (stall window), 1: must be high (window exit), 2: don't care
   function automatic int ready_req(input int k);
      int fin_k;
      fin_k = SD + CPP;
      for (int p = 0; p < NPIX; p++) begin
         if ((k >= fin_k) && (k < fin_k + stall[p])) return 0;
         if (k == fin_k + stall[p]) return 1;
         fin_k += CPP + stall[p];
      end
      return 2;
   endfunction

   task automatic drive_inputs(input int k, input bit noise);
      int w;
      w = ready_req(k);
      bus.ofm_ready = (w == 2) ? 1'($urandom_range(0, 1)) : w[0];
      bus.abort     = (abort_at > 0) && (k == abort_at);
      if (noise && (k <= done_cycle())) begin
         bus.start   = 1'($urandom_range(0, 1));
         bus.pe_mask = NPE'($urandom);
      end else begin
         bus.start = 1'b0;
      end
   endtask

   task automatic begin_layer(input logic [NPE-1:0] m);
      @(negedge clk);
      cap_mask      = m;
      bus.pe_mask   = m;
      bus.start     = 1'b1;
      bus.abort     = 1'b0;
      bus.ofm_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (observe() !== '0) $display("FAIL reset_state got=%h exp=0", observe());
      else passed++;
`ifdef CONV_SEQ_PERF_CNT_EN
      checks++;
      if (bus.stall_cycles !== 32'd0) $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles);
      else passed++;
`endif
      reset = 1'b0;
   endtask

   task automatic test_single_layer();
      logic [OBS_W-1:0] o, e;
      for (int p = 0; p < NPIX; p++) stall[p] = 0;
      abort_at = 0;
      begin_layer(16'hFFFF);
      for (int k = 1; k <= done_cycle() + 2; k++) begin
         @(negedge clk);
         o = observe(); e = model(k);
         checks++;
         if (o !== e) $display("FAIL single_layer k=%0d got=%h exp=%h", k, o, e);
         else passed++;
         if (k == 3 || k == 39 || k == 75) begin
            checks++;
            if (bus.PE_reset !== 16'hFFFF) $display("FAIL single_pe_reset k=%0d got=%h exp=ffff", k, bus.PE_reset);
            else passed++;
         end
         if (k == 38 || k == 74 || k == 110) begin
            checks++;
            if (bus.PE_finish !== 16'hFFFF) $display("FAIL single_pe_finish k=%0d got=%h exp=ffff", k, bus.PE_finish);
            else passed++;
         end
         if (k == 111 || k == 112) begin
            checks++;
            if ({bus.done, bus.busy} !== ((k == 111) ? 2'b11 : 2'b00))
               $display("FAIL single_done_busy k=%0d got=%b%b", k, bus.done, bus.busy);
            else passed++;
         end
         drive_inputs(k, 1'b0);
      end
      last_pix = NPIX - 1;
   endtask

   task automatic test_backpressure();
      logic [OBS_W-1:0] o, e;
      stall[0] = 0; stall[1] = 5; stall[2] = 0;
      abort_at = 0;
      begin_layer(16'hFFFF);
      for (int k = 1; k <= done_cycle() + 2; k++) begin
         @(negedge clk);
         o = observe(); e = model(k);
         checks++;
         if (o !== e) $display("FAIL backpressure k=%0d got=%h exp=%h", k, o, e);
         else passed++;
         if (k >= 75 && k <= 79) begin
            checks++;
            if (bus.pixel_idx !== 16'd1 || bus.PE_reset !== 16'h0)
               $display("FAIL bp_wait_hold k=%0d got pix=%0d rst=%h exp pix=1 rst=0", k, bus.pixel_idx, bus.PE_reset);
            else passed++;
         end
         if (k == 80) begin
            checks++;
            if (bus.PE_reset !== 16'hFFFF) $display("FAIL bp_third_reset got=%h exp=ffff", bus.PE_reset);
            else passed++;
         end
         drive_inputs(k, 1'b0);
      end
`ifdef CONV_SEQ_PERF_CNT_EN
      checks++;
      if (bus.stall_cycles !== 32'd5) $display("FAIL bp_stall_cycles got=%0d exp=5", bus.stall_cycles);
      else passed++;
`endif
      last_pix = NPIX - 1;
   endtask

   task automatic test_mask();
      logic [OBS_W-1:0] o, e;
      for (int p = 0; p < NPIX; p++) stall[p] = $urandom_range(0, 3);
      abort_at = 0;
      begin_layer(16'h00F0);
      for (int k = 1; k <= done_cycle() + 2; k++) begin
         @(negedge clk);
         o = observe(); e = model(k);
         checks++;
         if (o !== e) $display("FAIL mask_layer k=%0d got=%h exp=%h", k, o, e);
         else passed++;
         checks++;
         if (((bus.PE_reset | bus.PE_finish) & 16'hFF0F) !== 16'h0)
            $display("FAIL mask_lanes k=%0d got rst=%h fin=%h exp lanes 4-7 only", k, bus.PE_reset, bus.PE_finish);
         else passed++;
         drive_inputs(k, 1'b1);
      end
      last_pix = NPIX - 1;
   endtask

   task automatic test_abort();
      logic [OBS_W-1:0] o, e;
      for (int p = 0; p < NPIX; p++) stall[p] = 0;
      abort_at = 50;
      begin_layer(16'h5A5A);
      for (int k = 1; k <= abort_at + 3; k++) begin
         @(negedge clk);
         o = observe(); e = model(k);
         checks++;
         if (o !== e) $display("FAIL abort k=%0d got=%h exp=%h", k, o, e);
         else passed++;
         if (k == abort_at + 1) begin
            checks++;
            if (bus.pixel_idx !== 16'd1 || bus.cal_start !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
               $display("FAIL abort_idle got pix=%0d cal=%b done=%b busy=%b exp pix=1 cal=0 done=0 busy=0",
                        bus.pixel_idx, bus.cal_start, bus.done, bus.busy);
            else passed++;
         end
         drive_inputs(k, 1'b0);
      end
      abort_at = 0;
      last_pix = 1;
   endtask

   task automatic test_start_ignored();
      logic [OBS_W-1:0] e;
      e = {3'b000, {NPE{1'b0}}, {NPE{1'b0}}, PW'(last_pix)};
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.abort = 1'b0;
         checks++;
         if (observe() !== e) $display("FAIL start_abort_idle k=%0d got=%h exp=%h", k, observe(), e);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      logic [OBS_W-1:0] o, e;
      for (int p = 0; p < NPIX; p++) stall[p] = 0;
      abort_at = 0;
      begin_layer(16'hFFFF);
      for (int k = 1; k <= 74; k++) begin
         @(negedge clk);
         o = observe(); e = model(k);
         checks++;
         if (o !== e) $display("FAIL async_pre k=%0d got=%h exp=%h", k, o, e);
         else passed++;
         if (k < 74) drive_inputs(k, 1'b0);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (observe() !== '0) $display("FAIL async_reset got=%h exp=0", observe());
      else passed++;
`ifdef CONV_SEQ_PERF_CNT_EN
      checks++;
      if (bus.stall_cycles !== 32'd0) $display("FAIL async_reset_stall got=%0d exp=0", bus.stall_cycles);
      else passed++;
`endif
      #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      last_pix  = 0;
   endtask

   task automatic test_random();
      logic [OBS_W-1:0] o, e;
      for (int n = 0; n < 3; n++) begin
         for (int p = 0; p < NPIX; p++) stall[p] = $urandom_range(0, 4);
         abort_at = 0;
         begin_layer(NPE'($urandom));
         for (int k = 1; k <= done_cycle() + 2; k++) begin
            @(negedge clk);
            o = observe(); e = model(k);
            checks++;
            if (o !== e) $display("FAIL random_layer%0d k=%0d got=%h exp=%h", n, k, o, e);
            else passed++;
`ifdef CONV_SEQ_PERF_CNT_EN
            checks++;
            if (bus.stall_cycles !== 32'(model_stall(k)))
               $display("FAIL random_stall%0d k=%0d got=%0d exp=%0d", n, k, bus.stall_cycles, model_stall(k));
            else passed++;
`endif
            drive_inputs(k, 1'b1);
         end
         last_pix = NPIX - 1;
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.pe_mask   = '0;
      bus.ofm_ready = 1'b0;
      for (int p = 0; p < NPIX; p++) stall[p] = 0;
      abort_at = 0;
      cap_mask = '0;
      last_pix = 0;
      test_reset();
      test_single_layer();
      test_backpressure();
      test_mask();
      test_abort();
      test_start_ignored();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
